// File: rtl/eink_spi_arbiter.sv
// Two-requester SPI mode-0 bus arbiter for the e-ink module (display controller and frame SRAM).
// Holds a round-robin grant per transaction, shifts bytes MSB first and enforces a CS gap.
module eink_spi_arbiter #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_disp_n,
    output logic       cs_sram_n
);

    localparam int MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_BYTE,
        SHIFT,
        RELEASE
    } state_e;

    state_e           state_q;
    logic [1:0]       gnt_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic             sck_q;
    logic             mosi_q;
    logic [6:0]       tx_sh_q;
    logic [7:0]       rx_sh_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             cs_disp_n_q;
    logic             cs_sram_n_q;

    // 1 selects the SRAM: a lone SRAM request, or a tie when the display was served last.
    logic pick_d;
    logic req_granted_d;

    assign pick_d        = req[1] & (~req[0] | ~last_grant_q);
    assign req_granted_d = |(req & gnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
            tx_sh_q      <= 7'd0;
            rx_sh_q      <= 8'd0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            cs_disp_n_q  <= 1'b1;
            cs_sram_n_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments only here, so every register in this block
            // sees the pre-edge value of every other one regardless of statement order.
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q        <= pick_d ? 2'b10 : 2'b01;
                        cs_disp_n_q  <= pick_d;
                        cs_sram_n_q  <= ~pick_d;
                        last_grant_q <= pick_d;
                        cnt_q        <= '0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_BYTE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_BYTE: begin
                    if (tx_valid) begin
                        tx_sh_q <= tx_data[6:0];
                        mosi_q  <= tx_data[7];
                        bit_q   <= 3'd0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else if (!req_granted_d) begin
                        gnt_q       <= 2'b00;
                        cs_disp_n_q <= 1'b1;
                        cs_sram_n_q <= 1'b1;
                        mosi_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= RELEASE;
                    end
                end
                SHIFT: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            rx_sh_q <= {rx_sh_q[6:0], miso};
                        end else if (bit_q == 3'd7) begin
                            rx_data_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= WAIT_BYTE;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            mosi_q  <= tx_sh_q[6];
                            tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                        end
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign tx_ready  = (state_q == WAIT_BYTE);
    assign busy      = (state_q != IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign cs_disp_n = cs_disp_n_q;
    assign cs_sram_n = cs_sram_n_q;

endmodule

// File: doc/eink_spi_arbiter.md
Name: eink_spi_arbiter

Overview:
- Shares one SPI mode-0 bus between the two slaves on the e-ink module: the display controller (requester 0, cs_disp_n) and the frame SRAM (requester 1, cs_sram_n).
- Grants the bus to one requester per transaction and holds that grant until the requester releases it.
- Runs the byte shift engine and enforces a minimum chip-select gap between transactions.
- Sits between the display/SRAM command sequencers and the uio SPI pins of the top-level driver.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period (>=1); byte time = 16*CLK_DIV clocks
CS_GAP, 2, minimum clk cycles both CS lines stay high between transactions (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req  input  2  per-requester bus request; held high for the whole transaction
gnt  output 2  one-hot grant, at most one bit set
tx_data  input  8  byte from the granted requester
tx_valid  input  1  tx_data valid (qualified by gnt)
tx_ready  output 1  high in WAIT_BYTE; transfer occurs when tx_valid && tx_ready
rx_data  output 8  byte shifted in from miso
rx_valid  output 1  one-cycle pulse; rx_data valid for the granted requester
busy  output 1  high in any state other than IDLE
sck  output 1  SPI clock, idles low
mosi  output 1  SPI data out, MSB first
miso  input  1  SPI data in
cs_disp_n  output 1  display chip select, active-low
cs_sram_n  output 1  SRAM chip select, active-low

Behaviour:
- Reset values: gnt=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, sck=0, mosi=0, cs_disp_n=1, cs_sram_n=1, last_grant=1, state=IDLE.
- Reset is asynchronous and takes effect immediately, including mid-byte. The partial byte is discarded and no rx_valid is issued.
- States: IDLE, SETUP, WAIT_BYTE, SHIFT, RELEASE.
- IDLE -> SETUP when any req bit is set. Grant selection:
  - If only one bit is set, grant that requester.
  - If both are set, grant the requester that is not last_grant.
  - On grant, update last_grant. The first tie after reset goes to the display.
- SETUP: assert gnt and the matching CS line. Wait CLK_DIV cycles, then go to WAIT_BYTE.
- WAIT_BYTE:
  - tx_ready=1.
  - On tx_valid: latch tx_data, drive mosi = bit7, go to SHIFT.
  - If req[granted] is low and tx_valid is low: go to RELEASE.
  - If both arrive in the same cycle, tx_valid wins.
- SHIFT: 8 SCK periods, each CLK_DIV clocks low then CLK_DIV clocks high.
  - On each rising edge, sample miso into the LSB of the shift register.
  - On each falling edge, shift mosi to the next bit.
  - After the 8th high phase: sck=0, rx_data = assembled byte, rx_valid pulses for 1 cycle, go to WAIT_BYTE.
  - Total SHIFT duration is exactly 16*CLK_DIV clocks.
- Dropping req during SHIFT does not abort the byte. The byte completes, then the transaction releases through WAIT_BYTE.
- RELEASE: deassert gnt and both CS lines, hold for CS_GAP cycles, then go to IDLE.
  - A pending request is granted from IDLE on the next cycle, so the CS gap is at least CS_GAP+1 clocks.
- Invariants:
  - Both CS lines are never low simultaneously.
  - sck toggles only while a CS line is low.
  - gnt and the CS lines never change within a transaction.
- Requests from the non-granted requester are ignored until IDLE. No preemption.

Test Plan:
1. CLK_DIV=2, CS_GAP=2; req=01; send 0xA5 then 0x3C, miso tied 1 -> cs_disp_n low throughout, exactly 16 sck rising edges, mosi bits 1010_0101 then 0011_1100 sampled at rising edges, two rx_valid pulses with rx_data=0xFF, cs_sram_n stays 1.
2. miso driven from a shift model returning 0x5A during a 0x00 write on requester 1 -> cs_sram_n low, rx_data=0x5A on the rx_valid cycle, each SHIFT lasts 32 clocks with CLK_DIV=2.
3. req=11 asserted together after reset, each requester sends one byte then drops req -> display is granted first; then, after at least 3 clocks with both CS high, the SRAM is granted.
4. Both request again after test 3 -> display is granted (round-robin alternates, last_grant=SRAM).
5. req dropped one cycle after the byte starts -> byte completes with 8 full sck periods and rx_valid fires, then RELEASE; busy falls CS_GAP+1 clocks after rx_valid.
6. rst pulsed at sck edge 4 of a byte -> same cycle: sck=0, both CS=1, gnt=0, busy=0, no rx_valid; a new req=10 afterwards works normally.
